reg_file_scoreboard: RTL and testbench

//  Parametrised CPU register file with per-register scoreboard (busy bits) for the pipelined core.
//  NUM_RD combinational read ports, one synchronous write port, same-cycle write->read bypass.

---
 rtl/reg_file_if.sv | 37 +++
 rtl/reg_file_scoreboard.sv | 78 +++++++
 tb/tb_reg_file_scoreboard.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: bundles the register-file read, write, reserve and status signals
// Ports:
//   master modport - issue/writeback side: drives addresses, write data, reserve and flush
//   slave modport  - register file: returns read data, busy flags and busy summary
// Signals:
//   rd_addr/rd_data/rd_busy - NUM_RD read ports, port i at slice i of each vector
//   wr_en/wr_addr/wr_data   - synchronous write port
//   rsv_en/rsv_addr         - marks a destination register pending
//   flush                   - clears every pending mark
//   any_busy/busy_count     - registered summary of the busy vector
interface reg_file_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     flush;
    logic                     any_busy;
    logic [CNT_W-1:0]         busy_count;
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy, any_busy, busy_count
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy, any_busy, busy_count
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with per-register busy scoreboard and write->read bypass
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - synchronous active-low reset
//   rf    - reg_file_if slave: reads, write, reserve, flush, busy summary
// Optional build macro ZERO_REG_EN: register 0 reads as zero and ignores writes/reserves.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input logic        clk,
    input logic        rst_n,
    reg_file_if.slave  rf
);
`ifdef ZERO_REG_EN
    localparam logic [NUM_REGS-1:0] EN_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
    localparam logic [NUM_REGS-1:0] EN_MASK = '1;
`endif
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] wr_hit, rsv_hit;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    // Decoding against each register index means out-of-range addresses never match anything.
    always_comb begin
        wr_hit = '0;
        rsv_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = EN_MASK[r] && rf.wr_en && rf.wr_addr == ADDR_W'(r);
            rsv_hit[r] = EN_MASK[r] && rf.rsv_en && rf.rsv_addr == ADDR_W'(r);
        end
    end
    // Busy priority: flush over reserve over write-clear; reset handled in the register.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = wr_hit[r] ? rf.wr_data : regs_q[r];
            busy_d[r] = rf.flush ? 1'b0 : rsv_hit[r] ? 1'b1 : wr_hit[r] ? 1'b0 : busy_q[r];
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            busy_q <= '0;
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q <= cnt_d;
        end
    end
    // Same-cycle write is forwarded to readers; reserve/flush only show up next cycle.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rf.rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rd_data_o[p*DATA_W +: DATA_W] = wr_hit[r] ? rf.wr_data : regs_q[r];
                    rd_busy_o[p] = busy_q[r] && !wr_hit[r];
                end
            end
        end
    end
    assign rf.rd_data = rd_data_o;
    assign rf.rd_busy = rd_busy_o;
    assign rf.busy_count = cnt_q;
    assign rf.any_busy = |busy_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: randomized scoreboard bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int NRD = 2;
    localparam int AW = $clog2(NR);
    localparam int CW = $clog2(NR + 1);
    typedef struct {
        logic [NRD*DW-1:0] d;
        logic [NRD-1:0]    b;
        logic              any;
        logic [CW-1:0]     cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    logic [DW-1:0] mem [NR];
    bit busy [NR];
    reg_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) rf ();
    reg_file_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rf(rf)
    );
    always #5 clk = ~clk;
    function automatic bit usable(input int a);
`ifdef ZERO_REG_EN
        return a != 0 && a < NR;
`else
        return a < NR;
`endif
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    // Monitor: outputs are combinationally valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rd_data%0d", p), 64'(rf.rd_data[p*DW +: DW]), 64'(e.d[p*DW +: DW]));
                chk($sformatf("rd_busy%0d", p), 64'(rf.rd_busy[p]), 64'(e.b[p]));
            end
            chk("any_busy", 64'(rf.any_busy), 64'(e.any));
            chk("busy_count", 64'(rf.busy_count), 64'(e.cnt));
        end
    end
    task automatic step(input logic rn, input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic re, input int ra, input logic fl, input int a0, input int a1,
                        input bit push);
        exp_t e;
        int n;
        int ad [NRD];
        @(posedge clk);
        #1;
        rst_n = rn;
        rf.wr_en = we;
        rf.wr_addr = AW'(wa);
        rf.wr_data = wd;
        rf.rsv_en = re;
        rf.rsv_addr = AW'(ra);
        rf.flush = fl;
        rf.rd_addr = {AW'(a1), AW'(a0)};
        ad[0] = a0;
        ad[1] = a1;
        n = 0;
        foreach (busy[r]) n += int'(busy[r]);
        e.cnt = CW'(n);
        e.any = n != 0;
        e.d = '0;
        e.b = '0;
        for (int p = 0; p < NRD; p++) begin
            if (!usable(ad[p])) begin
                e.d[p*DW +: DW] = '0;
                e.b[p] = 1'b0;
            end else if (we && wa == ad[p]) begin
                e.d[p*DW +: DW] = wd;
                e.b[p] = 1'b0;
            end else begin
                e.d[p*DW +: DW] = mem[ad[p]];
                e.b[p] = busy[ad[p]];
            end
        end
        if (push) q.push_back(e);
        if (!rn) begin
            foreach (mem[r]) begin
                mem[r] = '0;
                busy[r] = 1'b0;
            end
        end else begin
            if (we && usable(wa)) begin
                mem[wa] = wd;
                busy[wa] = 1'b0;
            end
            if (re && usable(ra)) busy[ra] = 1'b1;
            if (fl) foreach (busy[r]) busy[r] = 1'b0;
        end
    endtask
    initial begin
        rf.wr_en = 0;
        rf.wr_addr = '0;
        rf.wr_data = '0;
        rf.rsv_en = 0;
        rf.rsv_addr = '0;
        rf.flush = 0;
        rf.rd_addr = '0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 7, 1);
        // reset clears stored data
        step(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3, 1);
        step(0, 0, 0, 0, 1, 3, 0, 3, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 3, 0, 1);
        // bypass
        step(1, 1, 5, 32'h12345678, 0, 0, 0, 5, 5, 1);
        step(1, 0, 0, 0, 0, 0, 0, 5, 2, 1);
        // reserve r2 then r4, write r2
        step(1, 0, 0, 0, 1, 2, 0, 2, 4, 1);
        step(1, 0, 0, 0, 1, 4, 0, 2, 4, 1);
        step(1, 1, 2, 32'hA5A5A5A5, 0, 0, 0, 2, 4, 1);
        step(1, 0, 0, 0, 1, 4, 0, 2, 4, 1);
        // collision on busy r6
        step(1, 0, 0, 0, 1, 6, 0, 6, 0, 1);
        step(1, 1, 6, 32'hCAFEF00D, 1, 6, 0, 6, 6, 1);
        step(1, 0, 0, 0, 0, 0, 0, 6, 4, 1);
        // flush with reserve and write
        step(1, 0, 0, 0, 1, 1, 0, 1, 2, 1);
        step(1, 0, 0, 0, 1, 2, 0, 1, 2, 1);
        step(1, 0, 0, 0, 1, 7, 0, 7, 3, 1);
        step(1, 1, 5, 32'h0BADC0DE, 1, 3, 1, 1, 7, 1);
        step(1, 0, 0, 0, 0, 0, 0, 3, 5, 1);
        // register 0
        step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, i, 0, i, 7 - i, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 7, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 1), $urandom_range(0, NR - 1), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, NR - 1), $urandom_range(0, 15) == 0,
                 $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
